lane_reuse_arbiter: RTL

Upstream feeder for the lane reuse demux. It merges two producer streams, each with a valid/ready handshake, onto one shared Width-bit datalane and drives the sel0x/sel1x lane code that steers each word to outlane1 or outlane2. Each source has a one-entry holding register. Source 1 has fixed priority, and a starvation limit guarantees source 2 is served. Select codes are delayed one cycle relative to datalane so they line up with the demux's registered data path.

---
 rtl/lane_reuse_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/lane_reuse_arbiter.sv
// lane_reuse_arbiter
//   Feeds the lane reuse demux. Two valid/ready producer streams share one
//   registered data lane. Each source has a one-entry holding register. The
//   sel0x/sel1x lane code is delayed one cycle behind datalane so that it lines
//   up with the demux's registered data path.
//
//   Default arbitration: source 1 has fixed priority. After MaxBurst
//   consecutive source-1 grants with source 2 waiting, source 2 is served once.
//
//   Build option LANE_REUSE_RR_EN: when this macro is defined the arbiter is
//   strict round-robin. Source 1 wins the first contested grant. MaxBurst has
//   no effect in that build.
//
// Parameters:
//   Width     data lane width in bits
//   MaxBurst  source-1 grants allowed in a row while source 2 waits (1..15)
//
// Ports:
//   clk, resetn          clock; synchronous active-low reset
//   in1_data/valid/ready source 1 stream (words go to outlane1)
//   in2_data/valid/ready source 2 stream (words go to outlane2)
//   datalane             registered shared data lane; holds its value when idle
//   sel0x, sel1x         lane code: 01 = outlane1, 10 = outlane2, 00 = none
//   busy                 a holding register is full or a code is in flight

module lane_reuse_arbiter #(
  parameter int Width    = 8,
  parameter int MaxBurst = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [Width-1:0] in1_data,
  input  logic             in1_valid,
  output logic             in1_ready,
  input  logic [Width-1:0] in2_data,
  input  logic             in2_valid,
  output logic             in2_ready,
  output logic [Width-1:0] datalane,
  output logic             sel0x,
  output logic             sel1x,
  output logic             busy
);

  typedef enum logic [1:0] {
    LANE_NONE = 2'b00,
    LANE_OUT1 = 2'b01,
    LANE_OUT2 = 2'b10
  } lane_t;

  logic             full1, full2;
  logic [Width-1:0] hold1, hold2;
  logic             grant1, grant2;
  lane_t            sel_stage, sel_out, sel_next;
  logic [Width-1:0] lane_q;

`ifdef LANE_REUSE_RR_EN
  // Set when source 2 was granted last. It resets to source 2 so that
  // source 1 wins the first contested cycle.
  logic last2;

  always_comb begin
    grant1 = 1'b0;
    grant2 = 1'b0;
    if (full1 && full2) begin
      grant1 = last2;
      grant2 = ~last2;
    end else begin
      grant1 = full1;
      grant2 = full2;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      last2 <= 1'b1;
    end else if (grant1) begin
      last2 <= 1'b0;
    end else if (grant2) begin
      last2 <= 1'b1;
    end
  end
`else
  localparam logic [3:0] MAX_B = 4'(MaxBurst);

  // Counts source-1 grants made while source 2 waits.
  logic [3:0] starve_cnt;

  always_comb begin
    grant1 = 1'b0;
    grant2 = 1'b0;
    if (full1 && full2) begin
      grant1 = (starve_cnt < MAX_B);
      grant2 = ~grant1;
    end else begin
      grant1 = full1;
      grant2 = full2;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      starve_cnt <= '0;
    end else if (!full2 || grant2) begin
      starve_cnt <= '0;
    end else if (grant1 && (starve_cnt != MAX_B)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end
`endif

  // Grants depend only on registered state, so ready has no path from valid.
  assign in1_ready = ~full1 | grant1;
  assign in2_ready = ~full2 | grant2;

  // A refill on the same edge as a grant wins, so the register stays full.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      full1 <= 1'b0;
      hold1 <= '0;
    end else if (in1_valid && in1_ready) begin
      full1 <= 1'b1;
      hold1 <= in1_data;
    end else if (grant1) begin
      full1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      full2 <= 1'b0;
      hold2 <= '0;
    end else if (in2_valid && in2_ready) begin
      full2 <= 1'b1;
      hold2 <= in2_data;
    end else if (grant2) begin
      full2 <= 1'b0;
    end
  end

  always_comb begin
    sel_next = LANE_NONE;
    if (grant1) begin
      sel_next = LANE_OUT1;
    end else if (grant2) begin
      sel_next = LANE_OUT2;
    end
  end

  // The word moves onto the lane on the grant edge. Its code passes through
  // sel_stage and reaches the pins one edge later.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      lane_q    <= '0;
      sel_stage <= LANE_NONE;
      sel_out   <= LANE_NONE;
    end else begin
      if (grant1) begin
        lane_q <= hold1;
      end else if (grant2) begin
        lane_q <= hold2;
      end
      sel_stage <= sel_next;
      sel_out   <= sel_stage;
    end
  end

  assign datalane = lane_q;
  assign sel0x    = sel_out[0];
  assign sel1x    = sel_out[1];
  assign busy     = full1 | full2 | (sel_stage != LANE_NONE) | (sel_out != LANE_NONE);

  a_one_grant : assert property (@(posedge clk) disable iff (!resetn) !(grant1 && grant2));
  a_no_code3  : assert property (@(posedge clk) disable iff (!resetn) !(sel0x && sel1x));

endmodule
